// File: rtl/retire_trace_gen.sv
// Retire trace generator: filters dual-slot retirements down to register-writing
// records and emits them one per cycle in program order, buffering overflow in a FIFO.
module retire_trace_gen #(
    parameter int DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        ret0_valid,
    input  logic [31:0] ret0_pc,
    input  logic        ret0_wen,
    input  logic [4:0]  ret0_waddr,
    input  logic [31:0] ret0_wdata,
    input  logic        ret1_valid,
    input  logic [31:0] ret1_pc,
    input  logic        ret1_wen,
    input  logic [4:0]  ret1_waddr,
    input  logic [31:0] ret1_wdata,
    output logic        ret_ready,
    output logic [69:0] inst_retire,
    output logic [31:0] ret_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [69:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_p1;
    logic [CW-1:0] count;

    logic [69:0]   rec0;
    logic [69:0]   rec1;
    logic          rec0_ok;
    logic          rec1_ok;

    logic [69:0]   out_rec;
    logic          deq;
    logic [1:0]    enq_cnt;
    logic          wr_a_en;
    logic          wr_b_en;
    logic [69:0]   wr_a_data;
    logic [69:0]   wr_b_data;

    // Only registered occupancy feeds ret_ready, so upstream sees no comb loop.
    assign ret_ready = (count <= READY_MAX);

    assign rec0 = {ret0_wen, ret0_waddr, ret0_wdata, ret0_pc};
    assign rec1 = {ret1_wen, ret1_waddr, ret1_wdata, ret1_pc};

    assign rec0_ok = ret0_valid & ret_ready & ret0_wen & (ret0_waddr != 5'd0);
    assign rec1_ok = ret1_valid & ret_ready & ret1_wen & (ret1_waddr != 5'd0);

    assign wr_ptr_p1 = wr_ptr + 1'b1;

    // Oldest pending record goes out; whatever is left is queued behind the FIFO contents.
    always_comb begin
        out_rec   = '0;
        deq       = 1'b0;
        enq_cnt   = 2'd0;
        wr_a_en   = 1'b0;
        wr_b_en   = 1'b0;
        wr_a_data = rec0;
        wr_b_data = rec1;
        if (count != '0) begin
            out_rec = mem[rd_ptr];
            deq     = 1'b1;
            if (rec0_ok && rec1_ok) begin
                wr_a_en = 1'b1;
                wr_b_en = 1'b1;
                enq_cnt = 2'd2;
            end else if (rec0_ok) begin
                wr_a_en = 1'b1;
                enq_cnt = 2'd1;
            end else if (rec1_ok) begin
                wr_a_en   = 1'b1;
                wr_a_data = rec1;
                enq_cnt   = 2'd1;
            end
        end else if (rec0_ok) begin
            out_rec = rec0;
            if (rec1_ok) begin
                wr_a_en   = 1'b1;
                wr_a_data = rec1;
                enq_cnt   = 2'd1;
            end
        end else if (rec1_ok) begin
            out_rec = rec1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inst_retire <= '0;
            ret_cnt     <= '0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(enq_cnt);
            rd_ptr      <= rd_ptr + AW'(deq);
            count       <= count + CW'(enq_cnt) - CW'(deq);
            inst_retire <= out_rec;
            if (out_rec[69]) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end

    // Storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge sys_clk) begin
        if (wr_a_en) begin
            mem[wr_ptr] <= wr_a_data;
        end
        if (wr_b_en) begin
            mem[wr_ptr_p1] <= wr_b_data;
        end
    end

endmodule

// File: tb/tb_retire_trace_gen.sv
// Directed bench for retire_trace_gen: bypass, filtering, back-pressure, pointer wrap,
// asynchronous reset and counter wrap.
module tb_retire_trace_gen;

    logic        sys_clk;
    logic        sys_reset_n;
    logic        ret0_valid;
    logic [31:0] ret0_pc;
    logic        ret0_wen;
    logic [4:0]  ret0_waddr;
    logic [31:0] ret0_wdata;
    logic        ret1_valid;
    logic [31:0] ret1_pc;
    logic        ret1_wen;
    logic [4:0]  ret1_waddr;
    logic [31:0] ret1_wdata;
    logic        ret_ready;
    logic [69:0] inst_retire;
    logic [31:0] ret_cnt;

    int n_checks = 0;
    int n_errors = 0;

    retire_trace_gen #(.DEPTH(4)) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .ret0_valid  (ret0_valid),
        .ret0_pc     (ret0_pc),
        .ret0_wen    (ret0_wen),
        .ret0_waddr  (ret0_waddr),
        .ret0_wdata  (ret0_wdata),
        .ret1_valid  (ret1_valid),
        .ret1_pc     (ret1_pc),
        .ret1_wen    (ret1_wen),
        .ret1_waddr  (ret1_waddr),
        .ret1_wdata  (ret1_wdata),
        .ret_ready   (ret_ready),
        .inst_retire (inst_retire),
        .ret_cnt     (ret_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] mk_rec(input int idx);
        logic [31:0] pc;
        logic [4:0]  wa;
        pc = 32'(idx * 4);
        wa = 5'((idx % 31) + 1);
        return {1'b1, wa, ~pc, pc};
    endfunction

    task automatic clear_slots();
        ret0_valid = 1'b0; ret0_pc = '0; ret0_wen = 1'b0; ret0_waddr = '0; ret0_wdata = '0;
        ret1_valid = 1'b0; ret1_pc = '0; ret1_wen = 1'b0; ret1_waddr = '0; ret1_wdata = '0;
    endtask

    task automatic drive0(input logic [69:0] r);
        ret0_valid = 1'b1; ret0_wen = r[69]; ret0_waddr = r[68:64];
        ret0_wdata = r[63:32]; ret0_pc = r[31:0];
    endtask

    task automatic drive1(input logic [69:0] r);
        ret1_valid = 1'b1; ret1_wen = r[69]; ret1_waddr = r[68:64];
        ret1_wdata = r[63:32]; ret1_pc = r[31:0];
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int issued;
        int emitted;
        int cycles;
        logic [69:0] r;

        clear_slots();
        sys_reset_n = 1'b0;
        #3;
        check_val("rst_ready", ret_ready, 1);
        check_val("rst_inst", inst_retire, 0);
        check_val("rst_cnt", ret_cnt, 0);
        step();
        sys_reset_n = 1'b1;
        step();

        // single record through the bypass path
        r = {1'b1, 5'd5, 32'hDEADBEEF, 32'h1000};
        drive0(r);
        step();
        clear_slots();
        check_val("single_rec", inst_retire, r);
        check_val("single_cnt", ret_cnt, 1);
        step();
        check_val("single_gone", inst_retire, 0);
        check_val("single_cnt_hold", ret_cnt, 1);

        // filtered slots: waddr 0 and wen 0
        drive0({1'b1, 5'd0, 32'h11111111, 32'h2000});
        drive1({1'b0, 5'd3, 32'h22222222, 32'h2004});
        step();
        clear_slots();
        check_val("filter_inst", inst_retire, 0);
        check_val("filter_cnt", ret_cnt, 1);
        step();
        check_val("filter_inst2", inst_retire, 0);
        check_val("filter_cnt2", ret_cnt, 1);

        // three dual retires, back-pressure, gapless output
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("dual_ready_%0d", k), ret_ready, 1);
            drive0(mk_rec(2 * k));
            drive1(mk_rec(2 * k + 1));
            step();
            check_val($sformatf("dual_out_%0d", k), inst_retire, mk_rec(k));
        end
        check_val("dual_full_ready", ret_ready, 0);
        drive0(mk_rec(50));
        drive1(mk_rec(51));
        step();
        clear_slots();
        check_val("dual_out_3", inst_retire, mk_rec(3));
        check_val("dual_ready_back", ret_ready, 1);
        step();
        check_val("dual_out_4", inst_retire, mk_rec(4));
        step();
        check_val("dual_out_5", inst_retire, mk_rec(5));
        step();
        check_val("dual_drained", inst_retire, 0);
        check_val("dual_cnt", ret_cnt, 7);

        // 20 dual retires with ready honoured; scoreboard in acceptance order
        issued  = 0;
        emitted = 0;
        cycles  = 0;
        while ((emitted < 40) && (cycles < 300)) begin
            if (ret_ready && issued < 40) begin
                drive0(mk_rec(100 + issued));
                drive1(mk_rec(101 + issued));
                issued += 2;
            end else begin
                clear_slots();
            end
            step();
            cycles++;
            if (inst_retire[69]) begin
                check_val($sformatf("wrap_rec_%0d", emitted), inst_retire, mk_rec(100 + emitted));
                emitted++;
            end
        end
        clear_slots();
        check_val("wrap_emitted", 32'(emitted), 40);
        step();
        check_val("wrap_idle", inst_retire, 0);
        check_val("wrap_count", 70'(dut.count), 0);
        check_val("wrap_cnt", ret_cnt, 47);

        // fill FIFO with 3 records, then reset between edges
        for (int k = 0; k < 3; k++) begin
            drive0(mk_rec(200 + 2 * k));
            drive1(mk_rec(201 + 2 * k));
            step();
        end
        check_val("pre_rst_out", inst_retire, mk_rec(202));
        check_val("pre_rst_count", 70'(dut.count), 3);
        #2;
        sys_reset_n = 1'b0;
        #1;
        check_val("mid_rst_inst", inst_retire, 0);
        check_val("mid_rst_cnt", ret_cnt, 0);
        check_val("mid_rst_count", 70'(dut.count), 0);
        check_val("mid_rst_ready", ret_ready, 1);
        drive0(mk_rec(206));
        step();
        check_val("in_rst_inst", inst_retire, 0);
        clear_slots();
        sys_reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val($sformatf("post_rst_inst_%0d", k), inst_retire, 0);
        end
        check_val("post_rst_cnt", ret_cnt, 0);

        // counter wrap
        force dut.ret_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.ret_cnt;
        check_val("cwrap_forced", ret_cnt, 32'hFFFF_FFFF);
        drive0(mk_rec(300));
        step();
        clear_slots();
        check_val("cwrap_rec", inst_retire, mk_rec(300));
        check_val("cwrap_cnt", ret_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
